mul16_seq: RTL and testbench

MUL16_SEQ -- requirements
Module: mul16_seq

---
 rtl/mul16_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_mul16_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq.sv
// -----------------------------------------------------------------------------
// mul16_seq -- sequential 16x16 -> 32 shift-and-add multiplier
//
// One multiply takes 16 RUN cycles plus one DONE cycle. The only adder on
// the datapath is a single 16-bit ripple-carry add16bits instance. Each RUN
// cycle conditionally adds the multiplicand into the high half of the
// accumulator and then shifts the accumulator right by one.
//
// Configuration macro:
//   MUL16_SIGNED_EN  when defined, a and b are two's complement. Operand
//                    magnitudes are captured at start, the result sign is
//                    registered, and the product is negated as it is loaded.
//                    When undefined, operands are unsigned and no sign logic
//                    exists.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous, active-high reset
//   start    in   1   multiply request, sampled only in IDLE
//   a        in  16   multiplicand, captured on an accepted start
//   b        in  16   multiplier, captured on an accepted start
//   product  out 32   result, valid with done and held until the next start
//   busy     out  1   high in RUN and DONE
//   done     out  1   single-cycle pulse marking a valid product
// -----------------------------------------------------------------------------

// 16-bit ripple-carry adder built from explicit full-adder equations.
module add16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        carry_out
);

  logic [16:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[16];

endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Datapath registers. acc holds {hi, lo}: lo starts as the multiplier and
  // is shifted out one bit per cycle while partial sums shift in from hi.
  logic [15:0] mcand_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;
  logic [31:0] product_q;

  // FSM decode strobes.
  logic        load;
  logic        step;
  logic        last_iter;

  // Captured operand values (magnitudes in the signed build).
  logic [15:0] a_cap;
  logic [15:0] b_cap;

  // One shift-and-add iteration.
  logic [15:0] add_sum;
  logic        add_co;
  logic [15:0] hi_sel;
  logic        co_sel;
  logic [31:0] acc_shift;
  logic [31:0] product_load;

`ifdef MUL16_SIGNED_EN
  logic        sign_q;

  // Two's-complement negation as invert-then-increment with an explicit
  // carry chain, so no extra arithmetic adder appears on the datapath.
  function automatic logic [15:0] neg16(input logic [15:0] x);
    logic [15:0] r;
    logic        c;
    c = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r[i] = ~x[i] ^ c;
      c    = ~x[i] & c;
    end
    return r;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    logic [31:0] r;
    logic        c;
    c = 1'b1;
    for (int i = 0; i < 32; i++) begin
      r[i] = ~x[i] ^ c;
      c    = ~x[i] & c;
    end
    return r;
  endfunction

  // -32768 maps to 0x8000, which is the correct unsigned magnitude.
  assign a_cap        = a[15] ? neg16(a) : a;
  assign b_cap        = b[15] ? neg16(b) : b;
  assign product_load = sign_q ? neg32(acc_shift) : acc_shift;
`else
  assign a_cap        = a;
  assign b_cap        = b;
  assign product_load = acc_shift;
`endif

  add16bits u_add (
    .a         (acc_q[31:16]),
    .b         (mcand_q),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  // The adder carry becomes the new MSB after the shift, so nothing is lost
  // even when hi + mcand overflows 16 bits.
  assign hi_sel    = acc_q[0] ? add_sum : acc_q[31:16];
  assign co_sel    = acc_q[0] & add_co;
  assign acc_shift = {co_sel, hi_sel, acc_q[15:1]};

  assign last_iter = (cnt_q == 5'd15);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers, not a memory array, so all of them are
  // cleared on reset; an aborted multiply must leave no residue behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MUL16_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else if (load) begin
      mcand_q <= a_cap;
      acc_q   <= {16'h0000, b_cap};
      cnt_q   <= '0;
`ifdef MUL16_SIGNED_EN
      sign_q  <= a[15] ^ b[15];
`endif
    end else if (step) begin
      acc_q <= acc_shift;
      cnt_q <= cnt_q + 5'd1;
      // The product register is written only here, on the RUN->DONE edge,
      // so it holds its value through DONE and IDLE.
      if (last_iter) begin
        product_q <= product_load;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul16_seq.sv
// -----------------------------------------------------------------------------
// tb_mul16_seq -- self-checking bench for mul16_seq
//
// Table-driven vectors run through a scoreboard queue: the expected product
// is pushed when start is driven and popped when done is seen. Hand-written
// sequences cover start held high, operand changes during RUN, and a reset
// that aborts a multiply. Compile with +define+MUL16_SIGNED_EN to use the
// signed vector table and signed reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fails  = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  mul16_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, independent of the shift-and-add structure.
  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL16_SIGNED_EN
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = {{16{x[15]}}, x};
    sy = {{16{y[15]}}, y};
    return 32'(sx * sy);
`else
    return {16'h0000, x} * {16'h0000, y};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one start pulse, follow it to done, and check latency, busy,
  // product, single-cycle done and product hold while idle.
  task automatic run_mul(input logic [15:0] va, input logic [15:0] vb, input string tag);
    int          k;
    bit          seen;
    bit          busy_ok;
    logic [31:0] exp;
    @(negedge clk);
    a     = va;
    b     = vb;
    start = 1'b1;
    sb_q.push_back(model(va, vb));
    @(posedge clk);
    #1;
    start   = 1'b0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(k), 32'd17);
    check({tag, " busy through run"}, 32'(busy_ok), 32'd1);
    exp = sb_q.pop_front();
    check({tag, " product"}, product, exp);
    @(posedge clk);
    #1;
    check({tag, " done single pulse"}, 32'(done), 32'd0);
    check({tag, " busy low after done"}, 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " product held"}, product, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          done_cnt;
    int          k;
    bit          seen;
    int unsigned last_done;
    logic [31:0] exp;

`ifdef MUL16_SIGNED_EN
    vecs[0] = '{16'hFFFE, 16'h0003, 32'hFFFF_FFFA};
    vecs[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[2] = '{16'h7FFF, 16'hFFFF, 32'hFFFF_8001};
    vecs[3] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[4] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[5] = '{16'h8000, 16'h0001, 32'hFFFF_8000};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
`else
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[3] = '{16'h1234, 16'h5678, 32'h0626_0060};
    vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[6] = '{16'hAAAA, 16'h5555, model(16'hAAAA, 16'h5555)};
`endif

    // Reset state.
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset product", product, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors; the first one is also the first start after reset.
    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d literal", i), product, vecs[i].exp);
    end

    // start held high: results every 18 cycles; operands changed during RUN
    // must not disturb the in-flight multiply.
    @(negedge clk);
    a     = 16'd2;
    b     = 16'd3;
    start = 1'b1;
    sb_q.push_back(model(16'd2, 16'd3));
    last_done = 0;
    for (int r = 0; r < 3; r++) begin
      seen = 1'b0;
      for (k = 1; k <= 30; k++) begin
        @(posedge clk);
        #1;
        if (k == 3) begin
          a = 16'hFFFF;
          b = 16'hFFFF;
        end
        if (k == 12) begin
          a = 16'd2;
          b = 16'd3;
        end
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      check($sformatf("b2b%0d done seen", r), 32'(seen), 32'd1);
      exp = sb_q.pop_front();
      check($sformatf("b2b%0d product", r), product, exp);
      check($sformatf("b2b%0d literal", r), product, 32'h6);
      if (r > 0) check($sformatf("b2b%0d interval", r), cyc - last_done, 32'd18);
      last_done = cyc;
      if (r < 2) sb_q.push_back(model(16'd2, 16'd3));
      else start = 1'b0;
    end
    repeat (3) @(posedge clk);

    // Reset during RUN iteration 8: no done, product cleared. The aborted
    // multiply pushes nothing to the scoreboard.
    @(negedge clk);
    a     = 16'h00FF;
    b     = 16'h0100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", product, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort no done pulse", 32'(done_cnt), 32'd0);
    check("abort product stays", product, 32'h0);

    run_mul(16'd7, 16'd9, "after_abort");
    check("after_abort literal", product, 32'h0000_003F);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
